// File: rtl/stopwatch_lap_ctrl_pkg.sv
// Shared types and constants for the stopwatch core.
// Optional lap counter is enabled with the LAP_COUNT_EN macro (see the top-level module).
package stopwatch_pkg;

    localparam int MAX_DIGITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        PAUSE,
        LAP,
        LAP_PAUSED
    } sw_state_t;

    // Tens-of-seconds and tens-of-minutes count 0..5; every other digit counts 0..9.
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// Button-pulse / display bundle between the stopwatch core and its surroundings.
// lap_count exists only when LAP_COUNT_EN is defined.
interface stopwatch_lap_ctrl_if #(
    parameter int NUM_DIGITS = 6
);
    logic                    start_stop;
    logic                    lap;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] disp_digits;
    logic                    running;
    logic                    lap_active;
    logic                    overflow;
`ifdef LAP_COUNT_EN
    logic [7:0]              lap_count;
`endif

    modport master (
        output start_stop, lap, clear,
`ifdef LAP_COUNT_EN
        input  lap_count,
`endif
        input  disp_digits, running, lap_active, overflow
    );

    modport slave (
        input  start_stop, lap, clear,
`ifdef LAP_COUNT_EN
        output lap_count,
`endif
        output disp_digits, running, lap_active, overflow
    );
endinterface

// File: rtl/stopwatch_lap_ctrl_bcd_digit_counter.sv
// One BCD digit of the time cascade; counts 0..MAX and wraps to 0 on inc at MAX.
module bcd_digit_counter #(
    parameter logic [3:0] MAX = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] q,
    output logic       at_max
);

    assign at_max = (q == MAX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= 4'd0;
        end else if (inc) begin
            q <= at_max ? 4'd0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch core: 10 ms prescaler, BCD time cascade and start/stop/lap/clear FSM.
// Define LAP_COUNT_EN to add the saturating lap_count output.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV   = 1_000_000,
    parameter int NUM_DIGITS = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    stopwatch_lap_ctrl_if.slave  sw
);

    localparam int PW = $clog2(TICK_DIV);

    sw_state_t               state;
    sw_state_t               state_nxt;
    logic                    take_snap;
    logic                    do_clear;
    logic                    counting;
    logic                    frozen;
    logic                    tick;
    logic [PW-1:0]           prescale;
    logic [4*NUM_DIGITS-1:0] live;
    logic [4*NUM_DIGITS-1:0] snapshot;
    logic [NUM_DIGITS-1:0]   at_max;
    logic [NUM_DIGITS-1:0]   inc;
    logic                    overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Pulse priority is clear > start_stop > lap; a clear while counting is simply dropped.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        state_nxt = state;
        take_snap = 1'b0;
        do_clear  = 1'b0;
        unique case (state)
            IDLE: begin
                if (sw.clear) do_clear = 1'b1;
                else if (sw.start_stop) state_nxt = RUN;
            end
            RUN: begin
                if (sw.start_stop) state_nxt = PAUSE;
                else if (sw.lap) begin
                    state_nxt = LAP;
                    take_snap = 1'b1;
                end
            end
            LAP: begin
                if (sw.start_stop) state_nxt = LAP_PAUSED;
                else if (sw.lap) take_snap = 1'b1;
            end
            PAUSE: begin
                if (sw.clear) begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end else if (sw.start_stop) state_nxt = RUN;
            end
            LAP_PAUSED: begin
                if (sw.clear) begin
                    state_nxt = IDLE;
                    do_clear  = 1'b1;
                end else if (sw.start_stop) state_nxt = LAP;
                else if (sw.lap) state_nxt = PAUSE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign counting = (state == RUN) || (state == LAP);
    assign frozen   = (state == LAP) || (state == LAP_PAUSED);
    assign tick     = counting && (prescale == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else if (counting) begin
            prescale <= prescale + PW'(1);
        end
    end

    // Digit k advances on a tick only when every lower digit sits at its maximum.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        if (k == 0) begin : g_carry
            assign inc[k] = tick;
        end else begin : g_carry
            assign inc[k] = tick & (&at_max[k-1:0]);
        end

        bcd_digit_counter #(
            .MAX (digit_max(k))
        ) u_digit (
            .clk    (clk),
            .reset  (reset),
            .clr    (do_clear),
            .inc    (inc[k]),
            .q      (live[4*k +: 4]),
            .at_max (at_max[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            snapshot <= '0;
        end else if (take_snap) begin
            snapshot <= live;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= tick & (&at_max);
        end
    end

`ifdef LAP_COUNT_EN
    logic [7:0] lap_cnt;

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            lap_cnt <= 8'd0;
        end else if (take_snap && lap_cnt != 8'hFF) begin
            lap_cnt <= lap_cnt + 8'd1;
        end
    end

    assign sw.lap_count = lap_cnt;
`endif

    assign sw.disp_digits = frozen ? snapshot : live;
    assign sw.running     = counting;
    assign sw.lap_active  = frozen;
    assign sw.overflow    = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Self-checking bench for stopwatch_lap_ctrl against a centisecond-count reference model.
// Exercises lap_count checks when LAP_COUNT_EN is defined.
module tb_stopwatch_lap_ctrl;

    localparam int TICK_DIV = 4;
    localparam int ND       = 6;
    localparam int W        = 4 * ND;
    localparam int MOD      = (ND == 6) ? 360000 : (ND == 7) ? 3600000 : 36000000;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    stopwatch_lap_ctrl_if #(.NUM_DIGITS(ND)) sw ();

    stopwatch_lap_ctrl #(
        .TICK_DIV   (TICK_DIV),
        .NUM_DIGITS (ND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: elapsed time as a plain centisecond count; two flags describe the mode.
    bit m_counting;
    bit m_frozen;
    bit m_ovf;
    bit m_tick;
    int m_t;
    int m_snap;
    int m_phase;
    int m_laps;
    int m_old_t;

    always @(posedge clk) begin
        if (reset) begin
            m_counting = 0; m_frozen = 0; m_ovf = 0;
            m_t = 0; m_snap = 0; m_phase = 0; m_laps = 0;
        end else begin
            m_tick  = m_counting && (m_phase == TICK_DIV - 1);
            m_old_t = m_t;
            m_ovf   = 0;
            if (m_counting) m_phase = m_tick ? 0 : m_phase + 1;
            if (m_tick) begin
                m_t   = (m_t + 1) % MOD;
                m_ovf = (m_t == 0);
            end
            case ({m_counting, m_frozen})
                2'b00: begin
                    if (sw.clear) begin
                        m_t = 0; m_snap = 0; m_phase = 0; m_laps = 0;
                    end else if (sw.start_stop) m_counting = 1;
                end
                2'b10: begin
                    if (sw.start_stop) m_counting = 0;
                    else if (sw.lap) begin
                        m_frozen = 1; m_snap = m_old_t;
                        if (m_laps < 255) m_laps++;
                    end
                end
                2'b11: begin
                    if (sw.start_stop) m_counting = 0;
                    else if (sw.lap) begin
                        m_snap = m_old_t;
                        if (m_laps < 255) m_laps++;
                    end
                end
                default: begin
                    if (sw.clear) begin
                        m_frozen = 0; m_t = 0; m_snap = 0; m_phase = 0; m_laps = 0;
                    end else if (sw.start_stop) m_counting = 1;
                    else if (sw.lap) m_frozen = 0;
                end
            endcase
        end
    end

    function automatic logic [W-1:0] to_bcd(input int t);
        logic [W-1:0] r;
        int cc, s, m, h;
        r  = '0;
        cc = t % 100;
        s  = (t / 100) % 60;
        m  = (t / 6000) % 60;
        h  = t / 360000;
        r[3:0]   = 4'(cc % 10);
        r[7:4]   = 4'(cc / 10);
        r[11:8]  = 4'(s % 10);
        r[15:12] = 4'(s / 10);
        r[19:16] = 4'(m % 10);
        r[23:20] = 4'(m / 10);
        for (int k = 6; k < ND; k++) begin
            r[4*k +: 4] = 4'(h % 10);
            h = h / 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] exp_disp();
        return to_bcd(m_frozen ? m_snap : m_t);
    endfunction

    // Called at a falling edge; holds the pulses across exactly one rising edge.
    task automatic pulse(input bit ss, input bit lp, input bit cl);
        sw.start_stop = ss;
        sw.lap        = lp;
        sw.clear      = cl;
        @(negedge clk);
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
    endtask

    task automatic preload_max();
        force dut.g_digit[0].u_digit.q = 4'd9;
        force dut.g_digit[1].u_digit.q = 4'd9;
        force dut.g_digit[2].u_digit.q = 4'd9;
        force dut.g_digit[3].u_digit.q = 4'd5;
        force dut.g_digit[4].u_digit.q = 4'd9;
        force dut.g_digit[5].u_digit.q = 4'd5;
        @(negedge clk);
        release dut.g_digit[0].u_digit.q;
        release dut.g_digit[1].u_digit.q;
        release dut.g_digit[2].u_digit.q;
        release dut.g_digit[3].u_digit.q;
        release dut.g_digit[4].u_digit.q;
        release dut.g_digit[5].u_digit.q;
        m_t = MOD - 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checks++; if (sw.disp_digits !== '0) begin errors++; $display("FAIL reset_disp got %h exp 0", sw.disp_digits); end
        checks++; if (sw.running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", sw.running); end
        checks++; if (sw.lap_active !== 1'b0) begin errors++; $display("FAIL reset_lap_active got %b exp 0", sw.lap_active); end
        checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", sw.overflow); end
    endtask

    task automatic test_run_basic();
        pulse(1, 0, 0);
        repeat (40) @(negedge clk);
        checks++; if (sw.disp_digits !== 24'h000010) begin errors++; $display("FAIL run40_disp got %h exp 000010", sw.disp_digits); end
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL run40_running got %b exp 1", sw.running); end
        checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL run40_overflow got %b exp 0", sw.overflow); end
        checks++; if (sw.lap_active !== 1'b0) begin errors++; $display("FAIL run40_lap_active got %b exp 0", sw.lap_active); end
    endtask

    task automatic test_minute_carry();
        int n;
        n = 0;
        while (m_t != 5999 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n >= 30000) begin errors++; $display("FAIL carry_reach timeout got t=%0d exp 5999", m_t); end
        checks++; if (sw.disp_digits !== 24'h005999) begin errors++; $display("FAIL carry_pre got %h exp 005999", sw.disp_digits); end
        n = 0;
        while (m_t == 5999 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checks++; if (sw.disp_digits !== 24'h010000) begin errors++; $display("FAIL carry_post got %h exp 010000", sw.disp_digits); end
    endtask

    task automatic test_lap();
        int n;
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        checks++; if (sw.disp_digits !== '0) begin errors++; $display("FAIL lap_prep_clear got %h exp 0", sw.disp_digits); end
        pulse(1, 0, 0);
        n = 0;
        while (m_t != 5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++; if (sw.disp_digits !== 24'h000005) begin errors++; $display("FAIL lap_at5 got %h exp 000005", sw.disp_digits); end
        pulse(0, 1, 0);
        repeat (32) @(negedge clk);
        checks++; if (sw.disp_digits !== 24'h000005) begin errors++; $display("FAIL lap_frozen got %h exp 000005", sw.disp_digits); end
        checks++; if (sw.lap_active !== 1'b1) begin errors++; $display("FAIL lap_active got %b exp 1", sw.lap_active); end
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL lap_running got %b exp 1", sw.running); end
        pulse(0, 1, 0);
        checks++; if (sw.disp_digits !== 24'h000013) begin errors++; $display("FAIL lap_split got %h exp 000013", sw.disp_digits); end
        pulse(1, 0, 0);
        checks++; if (sw.running !== 1'b0 || sw.lap_active !== 1'b1) begin errors++; $display("FAIL lap_paused run/lap got %b%b exp 01", sw.running, sw.lap_active); end
        pulse(0, 1, 0);
        checks++; if (sw.disp_digits !== 24'h000013) begin errors++; $display("FAIL lap_release got %h exp 000013", sw.disp_digits); end
        checks++; if (sw.lap_active !== 1'b0) begin errors++; $display("FAIL lap_release_active got %b exp 0", sw.lap_active); end
    endtask

    task automatic test_clear_priority();
        pulse(1, 0, 0);
        repeat (10) @(negedge clk);
        pulse(1, 0, 1);
        checks++; if (sw.running !== 1'b0) begin errors++; $display("FAIL ssclr_running got %b exp 0", sw.running); end
        checks++; if (sw.disp_digits !== exp_disp()) begin errors++; $display("FAIL ssclr_disp got %h exp %h", sw.disp_digits, exp_disp()); end
        pulse(0, 0, 1);
        checks++; if (sw.disp_digits !== '0) begin errors++; $display("FAIL clr_pause got %h exp 0", sw.disp_digits); end
        pulse(1, 0, 0);
        repeat (9) @(negedge clk);
        pulse(0, 0, 1);
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL clr_run_running got %b exp 1", sw.running); end
        checks++; if (sw.disp_digits !== exp_disp()) begin errors++; $display("FAIL clr_run_disp got %h exp %h", sw.disp_digits, exp_disp()); end
        pulse(1, 0, 0);
        pulse(0, 0, 1);
    endtask

    task automatic test_overflow();
        int n;
        preload_max();
        checks++; if (sw.disp_digits !== 24'h595999) begin errors++; $display("FAIL ovf_preload got %h exp 595999", sw.disp_digits); end
        pulse(1, 0, 0);
        n = 0;
        while (m_t == MOD - 1 && n < 10) begin
            checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", sw.overflow); end
            @(negedge clk);
            n++;
        end
        checks++; if (sw.disp_digits !== '0) begin errors++; $display("FAIL ovf_wrap_disp got %h exp 0", sw.disp_digits); end
        checks++; if (sw.overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %b exp 1", sw.overflow); end
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL ovf_running got %b exp 1", sw.running); end
        @(negedge clk);
        checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL ovf_one_cycle got %b exp 0", sw.overflow); end
        checks++; if (sw.running !== 1'b1) begin errors++; $display("FAIL ovf_running_after got %b exp 1", sw.running); end
        pulse(1, 0, 0);
        pulse(0, 0, 1);
    endtask

    task automatic test_reset_mid();
        int n;
        preload_max();
        pulse(1, 0, 0);
        n = 0;
        while (m_phase != TICK_DIV - 1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (sw.overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got %b exp 0", sw.overflow); end
        checks++; if (sw.disp_digits !== '0) begin errors++; $display("FAIL rstmid_disp got %h exp 0", sw.disp_digits); end
        checks++; if (sw.running !== 1'b0 || sw.lap_active !== 1'b0) begin errors++; $display("FAIL rstmid_flags got %b%b exp 00", sw.running, sw.lap_active); end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 4000; i++) begin
            checks++; if (sw.disp_digits !== exp_disp()) begin errors++; $display("FAIL rand_disp cyc %0d got %h exp %h", i, sw.disp_digits, exp_disp()); end
            checks++; if (sw.running !== m_counting) begin errors++; $display("FAIL rand_running cyc %0d got %b exp %b", i, sw.running, m_counting); end
            checks++; if (sw.lap_active !== m_frozen) begin errors++; $display("FAIL rand_lap_active cyc %0d got %b exp %b", i, sw.lap_active, m_frozen); end
            checks++; if (sw.overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow cyc %0d got %b exp %b", i, sw.overflow, m_ovf); end
`ifdef LAP_COUNT_EN
            checks++; if (sw.lap_count !== 8'(m_laps)) begin errors++; $display("FAIL rand_lap_count cyc %0d got %0d exp %0d", i, sw.lap_count, m_laps); end
`endif
            r = int'($urandom_range(0, 15));
            sw.start_stop = (r == 0) || (r == 4);
            sw.lap        = (r == 1) || (r == 2) || (r == 4);
            sw.clear      = (r == 3) || (r == 4) || (r == 5);
            reset         = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
        reset         = 1'b0;
    endtask

`ifdef LAP_COUNT_EN
    task automatic test_lap_count();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        pulse(1, 0, 0);
        for (int i = 0; i < 300; i++) pulse(0, 1, 0);
        checks++; if (sw.lap_count !== 8'd255) begin errors++; $display("FAIL lapcnt_sat got %0d exp 255", sw.lap_count); end
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        checks++; if (sw.lap_count !== 8'd255) begin errors++; $display("FAIL lapcnt_release got %0d exp 255", sw.lap_count); end
        pulse(0, 0, 1);
        checks++; if (sw.lap_count !== 8'd0) begin errors++; $display("FAIL lapcnt_clear got %0d exp 0", sw.lap_count); end
        pulse(1, 0, 0);
        for (int i = 0; i < 3; i++) pulse(0, 1, 0);
        checks++; if (sw.lap_count !== 8'd3) begin errors++; $display("FAIL lapcnt_three got %0d exp 3", sw.lap_count); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (sw.lap_count !== 8'd0 || sw.disp_digits !== '0 || sw.running !== 1'b0) begin
            errors++; $display("FAIL lapcnt_reset got cnt=%0d disp=%h run=%b exp 0", sw.lap_count, sw.disp_digits, sw.running);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        sw.start_stop = 1'b0;
        sw.lap        = 1'b0;
        sw.clear      = 1'b0;
        test_reset();
        test_run_basic();
        test_minute_carry();
        test_lap();
        test_clear_priority();
        test_overflow();
        test_reset_mid();
        test_random();
`ifdef LAP_COUNT_EN
        test_lap_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
